icache_refill_axi: RTL and testbench

//  AXI4 read master for I-cache line refill; sits between the I-cache miss logic and the

---
 rtl/icache_refill_axi.sv | 150 +++++++++++++++
 tb/tb_icache_refill_axi.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_axi.sv
// I-cache line refill AXI4 read master: one burst per miss, beats gathered into a line buffer.
// Define ICACHE_REFILL_CRITFIRST_EN for a critical-word-first WRAP burst with an early crit pulse.
module icache_refill_axi #(
  parameter int         LINE_WORDS = 4,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [31:0]              req_addr_i,
  input  logic                     flush_i,
  output logic                     line_valid_o,
  output logic [32*LINE_WORDS-1:0] line_data_o,
  output logic                     line_err_o,
  output logic                     crit_valid_o,
  output logic [31:0]              crit_data_o,
  output logic                     arvalid_o,
  input  logic                     arready_i,
  output logic [31:0]              araddr_o,
  output logic [3:0]               arid_o,
  output logic [7:0]               arlen_o,
  output logic [2:0]               arsize_o,
  output logic [1:0]               arburst_o,
  input  logic                     rvalid_i,
  output logic                     rready_o,
  input  logic [31:0]              rdata_i,
  input  logic [1:0]               rresp_i,
  input  logic                     rlast_i,
  input  logic [3:0]               rid_i
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(LINE_WORDS - 1);
  localparam logic [31:0]      LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] AR   = 2'd1;
  localparam logic [1:0] R    = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]                     state;
  logic [31:0]                    addr;
  logic [LINE_WORDS-1:0][31:0]    line_buf;
  logic [IDX_W-1:0]               idx;
  logic [CNT_W-1:0]               cnt;
  logic                           err;
  logic                           flush;
  logic [IDX_W-1:0]               start_idx;
  logic [31:0]                    ar_addr;
  logic [1:0]                     ar_burst;
  logic                           in_ar;
  logic                           in_r;
  logic                           unused;

  assign unused = ^rid_i;

`ifdef ICACHE_REFILL_CRITFIRST_EN
  logic first;

  assign start_idx = req_addr_i[IDX_W+1:2];
  assign ar_addr   = {addr[31:2], 2'b00};
  assign ar_burst  = 2'b10;
  assign crit_valid_o = in_r && rvalid_i && first && !flush && !flush_i;
  assign crit_data_o  = crit_valid_o ? rdata_i : 32'd0;
`else
  assign start_idx = '0;
  assign ar_addr   = addr & LINE_MASK;
  assign ar_burst  = 2'b01;
  assign crit_valid_o = 1'b0;
  assign crit_data_o  = 32'd0;
`endif

  assign in_ar = (state == AR);
  assign in_r  = (state == R);

  // The reset term keeps req_ready low for as long as reset is held, not just after the edge.
  assign req_ready_o  = reset && (state == IDLE);
  assign arvalid_o    = in_ar;
  assign araddr_o     = in_ar ? ar_addr  : 32'd0;
  assign arburst_o    = in_ar ? ar_burst : 2'b00;
  assign arlen_o      = in_ar ? 8'(LINE_WORDS - 1) : 8'd0;
  assign arsize_o     = in_ar ? 3'b010 : 3'b000;
  assign arid_o       = in_ar ? AXI_ID : 4'd0;
  assign rready_o     = in_r;
  assign line_valid_o = (state == DONE) && !flush && !flush_i;
  assign line_data_o  = line_buf;
  assign line_err_o   = err;

  // Beats past LINE_WORDS still advance idx but never overwrite the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      addr     <= 32'd0;
      line_buf <= '0;
      idx      <= '0;
      cnt      <= '0;
      err      <= 1'b0;
      flush    <= 1'b0;
`ifdef ICACHE_REFILL_CRITFIRST_EN
      first    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr  <= req_addr_i;
            err   <= 1'b0;
            flush <= 1'b0;
            cnt   <= '0;
            idx   <= start_idx;
`ifdef ICACHE_REFILL_CRITFIRST_EN
            first <= 1'b1;
`endif
            state <= AR;
          end
        end
        AR: begin
          if (flush_i) flush <= 1'b1;
          if (arready_i) state <= R;
        end
        R: begin
          if (flush_i) flush <= 1'b1;
          if (rvalid_i) begin
            if (cnt != FULL_CNT) begin
              line_buf[idx] <= rdata_i;
              cnt           <= cnt + CNT_W'(1);
            end
            idx <= idx + IDX_W'(1);
`ifdef ICACHE_REFILL_CRITFIRST_EN
            first <= 1'b0;
`endif
            if (rresp_i != 2'b00) err <= 1'b1;
            if (rlast_i) begin
              if (cnt != LAST_CNT) err <= 1'b1;
              state <= DONE;
            end
          end
        end
        default: begin
          if (flush_i) flush <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_axi.sv
// Randomized bench for icache_refill_axi: an AXI slave driven from tasks plus a line-level model.
module tb_icache_refill_axi;

  localparam int LW = 4;
`ifdef ICACHE_REFILL_CRITFIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [31:0]   req_addr_i;
  logic          flush_i;
  logic          line_valid_o;
  logic [127:0]  line_data_o;
  logic          line_err_o;
  logic          crit_valid_o;
  logic [31:0]   crit_data_o;
  logic          arvalid_o;
  logic          arready_i;
  logic [31:0]   araddr_o;
  logic [3:0]    arid_o;
  logic [7:0]    arlen_o;
  logic [2:0]    arsize_o;
  logic [1:0]    arburst_o;
  logic          rvalid_i;
  logic          rready_o;
  logic [31:0]   rdata_i;
  logic [1:0]    rresp_i;
  logic          rlast_i;
  logic [3:0]    rid_i;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [LW];

  icache_refill_axi #(.LINE_WORDS(LW), .AXI_ID(4'd0)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .flush_i(flush_i),
    .line_valid_o(line_valid_o), .line_data_o(line_data_o), .line_err_o(line_err_o),
    .crit_valid_o(crit_valid_o), .crit_data_o(crit_data_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o), .arid_o(arid_o),
    .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .rlast_i(rlast_i), .rid_i(rid_i)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] modelLine();
    logic [127:0] l;
    for (int w = 0; w < LW; w++) l[w*32 +: 32] = model[w];
    return l;
  endfunction

  task automatic clearModel();
    for (int w = 0; w < LW; w++) model[w] = 32'd0;
  endtask

  task automatic waitReady();
    int n = 0;
    while (!req_ready_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("req_ready", req_ready_o, 1);
  endtask

  // One full refill: request, AR after ar_delay stall cycles, nbeats R beats with random gaps.
  // err_beat / flush_beat < 0 mean none; fixed selects 0xA0+k beat data.
  task automatic applyStimulus(input logic [31:0] addr, input int ar_delay, input int nbeats,
                               input int err_beat, input int flush_beat, input int gap_max,
                               input bit fixed);
    logic [31:0] exp_araddr;
    logic [1:0]  exp_burst;
    int          start;
    logic        exp_err;
    logic [31:0] d;
    logic        exp_crit;

    exp_araddr = CRIT ? {addr[31:2], 2'b00} : {addr[31:4], 4'h0};
    exp_burst  = CRIT ? 2'b10 : 2'b01;
    start      = CRIT ? int'(addr[3:2]) : 0;
    exp_err    = (nbeats != LW);

    waitReady();
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    checkOutput("arvalid", arvalid_o, 1);
    checkOutput("araddr", araddr_o, exp_araddr);
    checkOutput("arlen", arlen_o, 8'd3);
    checkOutput("arsize", arsize_o, 3'b010);
    checkOutput("arburst", arburst_o, exp_burst);
    checkOutput("arid", arid_o, 4'd0);
    checkOutput("req_ready_busy", req_ready_o, 0);

    for (int i = 0; i < ar_delay; i++) begin
      @(posedge clk); #1;
      checkOutput("arvalid_hold", arvalid_o, 1);
      checkOutput("araddr_hold", araddr_o, exp_araddr);
      checkOutput("rready_in_ar", rready_o, 0);
    end
    arready_i = 1'b1;
    @(posedge clk); #1;
    arready_i = 1'b0;
    checkOutput("arvalid_after", arvalid_o, 0);
    checkOutput("rready", rready_o, 1);

    for (int k = 0; k < nbeats; k++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk); #1;
        checkOutput("rready_gap", rready_o, 1);
        checkOutput("line_valid_gap", line_valid_o, 0);
      end
      d = fixed ? 32'hA0 + 32'(k) : $urandom;
      rvalid_i = 1'b1;
      rdata_i  = d;
      rresp_i  = (k == err_beat) ? 2'b10 : 2'b00;
      rlast_i  = (k == nbeats - 1);
      rid_i    = 4'($urandom);
      flush_i  = (k == flush_beat);
      #1;
      exp_crit = CRIT && (k == 0) && (flush_beat != 0);
      checkOutput("crit_valid", crit_valid_o, exp_crit);
      checkOutput("crit_data", crit_data_o, exp_crit ? d : 32'd0);
      if (k < LW) model[(start + k) % LW] = d;
      if (k == err_beat) exp_err = 1'b1;
      @(posedge clk); #1;
      rvalid_i = 1'b0;
      rlast_i  = 1'b0;
      rresp_i  = 2'b00;
      flush_i  = 1'b0;
    end

    checkOutput("line_valid", line_valid_o, flush_beat < 0);
    checkOutput("line_data", line_data_o, modelLine());
    checkOutput("line_err", line_err_o, exp_err);
    checkOutput("rready_done", rready_o, 0);
    @(posedge clk); #1;
    checkOutput("line_valid_pulse", line_valid_o, 0);
    checkOutput("req_ready_idle", req_ready_o, 1);
    checkOutput("line_data_hold", line_data_o, modelLine());
    checkOutput("line_err_hold", line_err_o, exp_err);
  endtask

  initial begin
    reset       = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = 32'd0;
    flush_i     = 1'b0;
    arready_i   = 1'b0;
    rvalid_i    = 1'b0;
    rdata_i     = 32'd0;
    rresp_i     = 2'b00;
    rlast_i     = 1'b0;
    rid_i       = 4'd0;
    clearModel();
    #1;
    checkOutput("rst_req_ready", req_ready_o, 0);
    checkOutput("rst_arvalid", arvalid_o, 0);
    checkOutput("rst_line_data", line_data_o, 128'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_release_ready", req_ready_o, 1);

    $display("[TB] directed refills");
    applyStimulus(32'h3000_0014, 0, 4, -1, -1, 0, 1'b1);
    applyStimulus(32'h3000_0014, 5, 4, -1, -1, 3, 1'b1);
    applyStimulus(32'h8000_0008, 0, 4, -1, -1, 0, 1'b0);
    applyStimulus(32'h1234_5678, 1, 4, 2, -1, 1, 1'b0);
    applyStimulus(32'h0000_0040, 0, 3, -1, -1, 0, 1'b0);
    applyStimulus(32'h0000_004C, 2, 5, -1, -1, 2, 1'b0);
    applyStimulus(32'hCAFE_0004, 0, 4, -1, 1, 1, 1'b0);
    applyStimulus(32'hCAFE_0004, 0, 4, -1, 0, 0, 1'b0);
    applyStimulus(32'hBEEF_0010, 0, 4, -1, -1, 0, 1'b0);

    $display("[TB] reset mid-burst");
    waitReady();
    req_valid_i = 1'b1;
    req_addr_i  = 32'h4000_0000;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    arready_i   = 1'b1;
    @(posedge clk); #1;
    arready_i = 1'b0;
    rvalid_i  = 1'b1;
    rdata_i   = 32'h5555_AAAA;
    @(posedge clk); #1;
    rdata_i = 32'h1111_2222;
    #2;
    reset = 1'b0;
    #1;
    clearModel();
    checkOutput("midrst_rready", rready_o, 0);
    checkOutput("midrst_req_ready", req_ready_o, 0);
    checkOutput("midrst_line_data", line_data_o, 128'd0);
    checkOutput("midrst_line_valid", line_valid_o, 0);
    checkOutput("midrst_crit_valid", crit_valid_o, 0);
    rvalid_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_ready_after", req_ready_o, 1);

    $display("[TB] random refills");
    for (int t = 0; t < 25; t++) begin
      int nb;
      int eb;
      int fb;
      nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 6)) : LW;
      eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      fb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      applyStimulus($urandom, $urandom_range(0, 4), nb, eb, fb, 2, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
